// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared memory-subsystem types for the three-port memory arbiter
package mem_arbiter_pkg;

  localparam int ADR_W  = 30;
  localparam int DATA_W = 32;
  localparam int BE_W   = 4;

  localparam logic [BE_W-1:0] READ_BYTEEN = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WB   = 2'd1,
    DC   = 2'd2,
    IC   = 2'd3
  } arb_state_e;

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_WB   = 2'd1,
    SEL_DC   = 2'd2,
    SEL_IC   = 2'd3
  } port_sel_e;

  function automatic arb_state_e sel_to_state(input port_sel_e sel);
    case (sel)
      SEL_WB:  return WB;
      SEL_DC:  return DC;
      SEL_IC:  return IC;
      default: return IDLE;
    endcase
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - requester and memory bus bundle seen by the memory arbiter
interface mem_arbiter_if;
  import mem_arbiter_pkg::*;

  logic [ADR_W-1:0]  wbadr;
  logic [DATA_W-1:0] wbdata;
  logic [BE_W-1:0]   wbbyteen;
  logic              wben;
  logic              wbdone;

  logic [ADR_W-1:0]  dcadr;
  logic              dcen;
  logic [DATA_W-1:0] dcdata;
  logic              dcdone;

  logic [ADR_W-1:0]  icadr;
  logic              icen;
  logic [DATA_W-1:0] icdata;
  logic              icdone;

  logic [ADR_W-1:0]  memadr;
  logic [DATA_W-1:0] memwritedata;
  logic [DATA_W-1:0] memreaddata;
  logic [BE_W-1:0]   membyteen;
  logic              memrwb;
  logic              memen;
  logic              memdone;

  modport master (
    input  wbadr, wbdata, wbbyteen, wben,
    output wbdone,
    input  dcadr, dcen,
    output dcdata, dcdone,
    input  icadr, icen,
    output icdata, icdone,
    output memadr, memwritedata, membyteen, memrwb, memen,
    input  memreaddata, memdone
  );

  modport slave (
    output wbadr, wbdata, wbbyteen, wben,
    input  wbdone,
    output dcadr, dcen,
    input  dcdata, dcdone,
    output icadr, icen,
    input  icdata, icdone,
    input  memadr, memwritedata, membyteen, memrwb, memen,
    output memreaddata, memdone
  );

endinterface

// File: rtl/mem_arb_prio.sv
// rtl/mem_arb_prio.sv - combinational port select: WB > DC > IC, IC promoted once starved
module mem_arb_prio
  import mem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 8,
  parameter int CNT_W        = $clog2(STARVE_LIMIT + 1)
) (
  input  logic             wben,
  input  logic             dcen,
  input  logic             icen,
  input  logic             wbdone,
  input  logic             dcdone,
  input  logic             icdone,
  input  logic [CNT_W-1:0] starve_cnt,
  output port_sel_e        sel,
  output logic             ic_elig
);

  logic wb_elig;
  logic dc_elig;
  logic starved;

  // a port in its done cycle sits out so it cannot be granted twice for one request
  assign wb_elig = wben & ~wbdone;
  assign dc_elig = dcen & ~dcdone;
  assign ic_elig = icen & ~icdone;
  assign starved = (starve_cnt == CNT_W'(STARVE_LIMIT));

  always_comb begin
    sel = SEL_NONE;
    if (starved && ic_elig) begin
      sel = SEL_IC;
    end else if (wb_elig) begin
      sel = SEL_WB;
    end else if (dc_elig) begin
      sel = SEL_DC;
    end else if (ic_elig) begin
      sel = SEL_IC;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-outstanding memory arbiter for write buffer, dcache and icache
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 8
) (
  input logic          clk,
  input logic          reset,
  mem_arbiter_if.master bus
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  arb_state_e        state;
  arb_state_e        state_next;
  port_sel_e         sel;
  logic              ic_elig;
  logic              grant;
  logic              complete;
  logic [CNT_W-1:0]  starve_cnt;

  logic [ADR_W-1:0]  memadr_q;
  logic [DATA_W-1:0] memwritedata_q;
  logic [BE_W-1:0]   membyteen_q;
  logic              memrwb_q;
  logic              memen_q;
  logic              wbdone_q;
  logic              dcdone_q;
  logic              icdone_q;
  logic [DATA_W-1:0] dcdata_q;
  logic [DATA_W-1:0] icdata_q;

  mem_arb_prio #(
    .STARVE_LIMIT (STARVE_LIMIT),
    .CNT_W        (CNT_W)
  ) u_prio (
    .wben       (bus.wben),
    .dcen       (bus.dcen),
    .icen       (bus.icen),
    .wbdone     (wbdone_q),
    .dcdone     (dcdone_q),
    .icdone     (icdone_q),
    .starve_cnt (starve_cnt),
    .sel        (sel),
    .ic_elig    (ic_elig)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    grant      = 1'b0;
    complete   = 1'b0;
    case (state)
      IDLE: begin
        if (sel != SEL_NONE) begin
          grant      = 1'b1;
          state_next = sel_to_state(sel);
        end
      end
      WB, DC, IC: begin
        if (bus.memdone) begin
          complete   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      memadr_q       <= '0;
      memwritedata_q <= '0;
      membyteen_q    <= '0;
      memrwb_q       <= 1'b1;
      memen_q        <= 1'b0;
      wbdone_q       <= 1'b0;
      dcdone_q       <= 1'b0;
      icdone_q       <= 1'b0;
      dcdata_q       <= '0;
      icdata_q       <= '0;
    end else begin
      wbdone_q <= 1'b0;
      dcdone_q <= 1'b0;
      icdone_q <= 1'b0;
      if (grant) begin
        memen_q <= 1'b1;
        case (sel)
          SEL_WB: begin
            memadr_q       <= bus.wbadr;
            memwritedata_q <= bus.wbdata;
            membyteen_q    <= bus.wbbyteen;
            memrwb_q       <= 1'b0;
          end
          SEL_DC: begin
            memadr_q    <= bus.dcadr;
            membyteen_q <= READ_BYTEEN;
            memrwb_q    <= 1'b1;
          end
          default: begin
            memadr_q    <= bus.icadr;
            membyteen_q <= READ_BYTEEN;
            memrwb_q    <= 1'b1;
          end
        endcase
      end
      if (complete) begin
        memen_q <= 1'b0;
        case (state)
          WB: wbdone_q <= 1'b1;
          DC: begin
            dcdone_q <= 1'b1;
            dcdata_q <= bus.memreaddata;
          end
          IC: begin
            icdone_q <= 1'b1;
            icdata_q <= bus.memreaddata;
          end
          default: ;
        endcase
      end
    end
  end

  // counts how often IC lost while it was actually waiting; saturates to force promotion
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (grant) begin
      if (sel == SEL_IC) begin
        starve_cnt <= '0;
      end else if (ic_elig && bus.icen && (starve_cnt != CNT_W'(STARVE_LIMIT))) begin
        starve_cnt <= starve_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.memadr       = memadr_q;
  assign bus.memwritedata = memwritedata_q;
  assign bus.membyteen    = membyteen_q;
  assign bus.memrwb       = memrwb_q;
  assign bus.memen        = memen_q;
  assign bus.wbdone       = wbdone_q;
  assign bus.dcdone       = dcdone_q;
  assign bus.icdone       = icdone_q;
  assign bus.dcdata       = dcdata_q;
  assign bus.icdata       = icdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  mem_arbiter_if bus();

  mem_arbiter #(.STARVE_LIMIT(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.wben = 1'b0;
    bus.dcen = 1'b0;
    bus.icen = 1'b0;
  endtask

  int grant_q[$];
  int cnt_q[$];

  task automatic collect_grants(input int n);
    grant_q.delete();
    cnt_q.delete();
    for (int c = 0; c < 4 * n + 4 && grant_q.size() < n; c++) begin
      @(negedge clk);
      if (bus.memen) begin
        grant_q.push_back(int'(bus.memadr));
        cnt_q.push_back(int'(dut.starve_cnt));
      end
    end
  endtask

  int exp_port[10] = '{1, 2, 1, 2, 1, 2, 1, 2, 3, 1};
  int exp_cnt[10]  = '{1, 2, 3, 4, 5, 6, 7, 8, 0, 0};

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    idle_inputs();
    bus.wbadr       = '0;
    bus.wbdata      = '0;
    bus.wbbyteen    = '0;
    bus.dcadr       = '0;
    bus.icadr       = '0;
    bus.memreaddata = '0;
    bus.memdone     = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);

    check("rst_memen",   64'(bus.memen), 64'(0));
    check("rst_memrwb",  64'(bus.memrwb), 64'(1));
    check("rst_memadr",  64'(bus.memadr), 64'(0));
    check("rst_wdata",   64'(bus.memwritedata), 64'(0));
    check("rst_byteen",  64'(bus.membyteen), 64'(0));
    check("rst_dones",   64'({bus.wbdone, bus.dcdone, bus.icdone}), 64'(0));
    check("rst_rdata",   64'({bus.dcdata, bus.icdata}), 64'(0));
    check("rst_starve",  64'(dut.starve_cnt), 64'(0));
    reset = 1'b0;

    // single write, memdone tied high: minimum latency
    bus.memdone  = 1'b1;
    bus.wben     = 1'b1;
    bus.wbadr    = 30'h0;
    bus.wbdata   = 32'hDEADBEEF;
    bus.wbbyteen = 4'b1011;
    @(negedge clk);
    check("wb_memen",   64'(bus.memen), 64'(1));
    check("wb_memrwb",  64'(bus.memrwb), 64'(0));
    check("wb_memadr",  64'(bus.memadr), 64'(0));
    check("wb_wdata",   64'(bus.memwritedata), 64'hDEADBEEF);
    check("wb_byteen",  64'(bus.membyteen), 64'(4'b1011));
    check("wb_done_early", 64'(bus.wbdone), 64'(0));
    bus.wben = 1'b0;
    @(negedge clk);
    check("wb_memen_off", 64'(bus.memen), 64'(0));
    check("wb_done",      64'(bus.wbdone), 64'(1));
    @(negedge clk);
    check("wb_done_once", 64'(bus.wbdone), 64'(0));

    // dcache read with memdone delayed 3 cycles; dcen dropped mid-grant
    bus.memdone     = 1'b0;
    bus.dcen        = 1'b1;
    bus.dcadr       = 30'h4AD;
    bus.memreaddata = 32'hAAAAAAAA;
    @(negedge clk);
    check("dc_memen1",  64'(bus.memen), 64'(1));
    check("dc_memrwb",  64'(bus.memrwb), 64'(1));
    check("dc_memadr",  64'(bus.memadr), 64'h4AD);
    check("dc_byteen",  64'(bus.membyteen), 64'hF);
    bus.dcen = 1'b0;
    for (int i = 2; i <= 4; i++) begin
      @(negedge clk);
      check($sformatf("dc_memen%0d", i), 64'(bus.memen), 64'(1));
      check($sformatf("dc_adr_hold%0d", i), 64'(bus.memadr), 64'h4AD);
      check($sformatf("dc_nodone%0d", i), 64'(bus.dcdone), 64'(0));
    end
    bus.memdone = 1'b1;
    @(negedge clk);
    check("dc_memen_off", 64'(bus.memen), 64'(0));
    check("dc_done",      64'(bus.dcdone), 64'(1));
    check("dc_data",      64'(bus.dcdata), 64'hAAAAAAAA);
    bus.memreaddata = 32'h55555555;
    @(negedge clk);
    check("dc_done_once", 64'(bus.dcdone), 64'(0));
    check("dc_data_hold", 64'(bus.dcdata), 64'hAAAAAAAA);

    // memdone while idle must not produce anything
    repeat (3) @(negedge clk);
    check("idle_memen", 64'(bus.memen), 64'(0));
    check("idle_dones", 64'({bus.wbdone, bus.dcdone, bus.icdone}), 64'(0));

    // WB and IC only: IC wins during WB's done cycle
    bus.memreaddata = 32'h12345678;
    bus.wbadr = 30'd1;
    bus.dcadr = 30'd2;
    bus.icadr = 30'd3;
    bus.wben  = 1'b1;
    bus.icen  = 1'b1;
    collect_grants(2);
    check("wbic_n",    64'(grant_q.size()), 64'(2));
    if (grant_q.size() == 2) begin
      check("wbic_g0", 64'(grant_q[0]), 64'(1));
      check("wbic_g1", 64'(grant_q[1]), 64'(3));
      check("wbic_c0", 64'(cnt_q[0]), 64'(1));
      check("wbic_c1", 64'(cnt_q[1]), 64'(0));
    end
    idle_inputs();
    repeat (3) @(negedge clk);
    check("wbic_icdata", 64'(bus.icdata), 64'h12345678);

    // all three requesting: WB/DC alternate until IC starves, then IC is promoted
    bus.wben = 1'b1;
    bus.dcen = 1'b1;
    bus.icen = 1'b1;
    collect_grants(10);
    check("starve_n", 64'(grant_q.size()), 64'(10));
    if (grant_q.size() == 10) begin
      for (int i = 0; i < 10; i++) begin
        check($sformatf("starve_g%0d", i), 64'(grant_q[i]), 64'(exp_port[i]));
        check($sformatf("starve_c%0d", i), 64'(cnt_q[i]), 64'(exp_cnt[i]));
      end
    end
    idle_inputs();
    repeat (3) @(negedge clk);

    // reset during a dcache grant abandons it; the late memdone is ignored
    bus.memdone     = 1'b0;
    bus.memreaddata = 32'hCAFEF00D;
    bus.dcadr       = 30'd5;
    bus.dcen        = 1'b1;
    @(negedge clk);
    check("rst_mid_memen", 64'(bus.memen), 64'(1));
    reset    = 1'b1;
    bus.dcen = 1'b0;
    @(negedge clk);
    reset       = 1'b0;
    bus.memdone = 1'b1;
    check("rst_mid_memen_off", 64'(bus.memen), 64'(0));
    @(negedge clk);
    check("rst_mid_dcdone", 64'(bus.dcdone), 64'(0));
    check("rst_mid_dcdata", 64'(bus.dcdata), 64'(0));
    check("rst_mid_state",  64'(dut.state), 64'(IDLE));
    check("rst_mid_memen2", 64'(bus.memen), 64'(0));
    @(negedge clk);
    check("rst_mid_dcdone2", 64'(bus.dcdone), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
